main_mem_arbiter: RTL and testbench

//  Shares the single 128-bit main memory (MainMem) between the instruction-cache refill port (read-only)
//  and the data-cache refill/writeback port (read/write). Round-robin arbitration, one transaction
//  in flight, sequences CS/OE/WE against the memory's Ready_Mem busy handshake, returns read data
//  and a one-cycle ack per transaction. Sits between the two cache controllers and MainMem.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/main_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_main_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter and its round-robin helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  // Requester ids; also the bit position of each requester in the req/grant vectors
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a collision goes to the side not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is actually taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; bit 0 = icache, bit 1 = dcache
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares MainMem between the icache refill port (read-only) and the dcache port (read/write).
// Latency: IDLE->ISSUE->WAIT_DONE->RESP, so at least 4 cycles plus the memory's busy time per transaction.
// Backpressure: requests are held by the caches until ack; new grants only from IDLE with mem_ready=1.
module main_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic               last_grant;
  logic               id_q;
  logic               we_q;
  logic [TMR_W-1:0]   timer;
  logic [DATA_W-1:0]  rd_buf;
  logic [1:0]         grant;
  logic               start;
  logic               win_d;
  logic               new_we;
  logic               tmo_hit;
  logic               go_wait;
  logic               go_done;
  logic               go_tmo;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, i_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant decode and the three ways out of an active transaction
  always_comb begin
    start   = (|grant) && mem_ready && (state == IDLE);
    win_d   = grant[1];
    new_we  = grant[1] & d_we;
    // timer holds the number of completed cycles in ISSUE/WAIT_DONE minus one
    tmo_hit = (timer >= TMR_W'(TIMEOUT - 1));
    go_wait = (state == ISSUE) && !mem_ready;
    go_done = (state == WAIT_DONE) && mem_ready;
    // Real memory progress wins over a timeout landing on the same edge
    go_tmo  = ((state == ISSUE) || (state == WAIT_DONE)) && !go_wait && !go_done && tmo_hit;
  end

  // Transaction sequencer: grant, strobe until memory goes busy, wait for idle, acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= REQ_I;
      id_q        <= REQ_I;
      we_q        <= 1'b0;
      timer       <= '0;
      rd_buf      <= '0;
      i_ack       <= 1'b0;
      i_rdata     <= '0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      mem_cs      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_we      <= 1'b0;
      mem_drive   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            id_q       <= win_d ? REQ_D : REQ_I;
            last_grant <= win_d ? REQ_D : REQ_I;
            we_q       <= new_we;
            mem_addr   <= win_d ? d_addr : i_addr;
            mem_wdata  <= win_d ? d_wdata : '0;
            mem_cs     <= 1'b1;
            mem_we     <= new_we;
            mem_oe     <= !new_we;
            mem_drive  <= new_we;
            timer      <= '0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (go_wait) begin
            // Memory has accepted the strobe; read data is on the bus at this edge
            rd_buf    <= mem_rdata;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_drive <= 1'b0;
            state     <= WAIT_DONE;
          end
          if (go_done || go_tmo) begin
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_drive <= 1'b0;
            state     <= RESP;
            if (go_tmo) begin
              timeout_err <= 1'b1;
            end
            if (id_q == REQ_D) begin
              d_ack <= 1'b1;
              if (!we_q) begin
                d_rdata <= go_tmo ? '0 : rd_buf;
              end
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= go_tmo ? '0 : rd_buf;
            end
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter against a behavioural MainMem that stays busy 6 cycles per op.
// Latency: expected ack timing is hand-computed from the edge sequence of each transaction.
// Backpressure: the memory model can be stuck idle to force the timeout path.
module tb_main_mem_arbiter;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_DB = {4{32'hDEAD_BEEF}};

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_ack;
  logic [127:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata;
  logic         d_ack;
  logic [127:0] d_rdata;
  logic         mem_cs;
  logic         mem_oe;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_drive;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b1;
  logic         busy;
  logic         timeout_err;

  int errors = 0;
  int checks = 0;

  // memory model state
  logic [127:0] mem_arr [0:255];
  logic         mdl_stuck;
  logic         mdl_load;
  int           mdl_cnt = 0;

  int cyc;
  int csn;
  int n;
  logic ia;
  logic da;

  always #5 clk = ~clk;

  main_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .mem_cs      (mem_cs),
    .mem_oe      (mem_oe),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_drive   (mem_drive),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // MainMem: on CS while idle, go busy for 6 cycles and perform the access
  always @(posedge clk) begin
    if (mdl_load) begin
      mem_arr[8'h10] <= PAT_A5;
      mem_arr[8'h20] <= '0;
    end
    if (mdl_stuck) begin
      mem_ready <= 1'b1;
      mdl_cnt   <= 0;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mem_ready <= 1'b1;
    end else if (mem_cs && mem_ready) begin
      mem_ready <= 1'b0;
      mdl_cnt   <= 6;
      if (mem_we && mem_drive) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else if (mem_oe) mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for either ack; report cycles, cs-high cycles and which ack fired
  task automatic wait_ack(input int limit, output int cycles, output int cs_cycles,
                          output logic got_i, output logic got_d);
    cycles = 0; cs_cycles = 0; got_i = 1'b0; got_d = 1'b0;
    while (cycles < limit && !got_i && !got_d) begin
      @(negedge clk);
      cycles++;
      if (mem_cs) cs_cycles++;
      got_i = i_ack;
      got_d = d_ack;
    end
  endtask

  initial begin
    reset = 1'b1; mdl_load = 1'b1; mdl_stuck = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_strobes", {mem_cs, mem_oe, mem_we, mem_drive}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    reset = 1'b0; mdl_load = 1'b0;
    @(negedge clk);

    // 2: icache read of 0x10
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("rd_strobes", {mem_cs, mem_oe, mem_we, mem_drive}, 4'b1100);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_busy", busy, 1);
    wait_ack(40, cyc, csn, ia, da);
    chk("rd_lat", cyc + 1, 9);
    chk("rd_cs_cycles", csn + 1, 2);
    chk("rd_which", {ia, da}, 2'b10);
    chk("rd_data", i_rdata, PAT_A5);
    i_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", i_ack, 0);
    chk("rd_idle", busy, 0);

    // 3: dcache write then read back of 0x20
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = PAT_DB;
    @(negedge clk);
    chk("wr_strobes", {mem_cs, mem_oe, mem_we, mem_drive}, 4'b1011);
    chk("wr_wdata", mem_wdata, PAT_DB);
    wait_ack(40, cyc, csn, ia, da);
    chk("wr_lat", cyc + 1, 9);
    chk("wr_which", {ia, da}, 2'b01);
    chk("wr_rdata_kept", d_rdata, 0);
    d_req = 1'b0;
    @(negedge clk);
    chk("wr_mem", mem_arr[8'h20], PAT_DB);
    d_we = 1'b0; d_req = 1'b1;
    wait_ack(40, cyc, csn, ia, da);
    chk("rdback_which", {ia, da}, 2'b01);
    chk("rdback_data", d_rdata, PAT_DB);
    d_req = 1'b0;
    @(negedge clk);

    // 4: collisions after reset: d first, then i, then d re-requesting loses to i's turn
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    wait_ack(40, cyc, csn, ia, da);
    chk("col1_which", {ia, da}, 2'b01);
    chk("col1_data", d_rdata, PAT_DB);
    d_addr = 32'h10;
    wait_ack(40, cyc, csn, ia, da);
    chk("col2_which", {ia, da}, 2'b10);
    chk("col2_data", i_rdata, PAT_A5);
    i_req = 1'b0;
    wait_ack(40, cyc, csn, ia, da);
    chk("col3_which", {ia, da}, 2'b01);
    chk("col3_data", d_rdata, PAT_A5);
    d_req = 1'b0;
    @(negedge clk);

    // 5: memory never goes busy -> forced completion after TIMEOUT cycles
    mdl_stuck = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    wait_ack(60, cyc, csn, ia, da);
    chk("tmo_lat", cyc, 16);
    chk("tmo_cs_cycles", csn, 15);
    chk("tmo_which", {ia, da}, 2'b10);
    chk("tmo_rdata", i_rdata, 0);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_strobes", {mem_cs, mem_oe, mem_we, mem_drive}, 0);
    i_req = 1'b0; mdl_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_idle", busy, 0);

    // 6: reset in WAIT_DONE, then a request waits in IDLE while memory is still busy
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (3) @(negedge clk);
    chk("wd_state", {busy, mem_cs}, 2'b10);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_strobes", {mem_cs, mem_oe, mem_we, mem_drive}, 0);
    chk("mrst_ack", {i_ack, d_ack}, 0);
    chk("mrst_tmo", timeout_err, 0);
    chk("mrst_rdata", d_rdata, 0);
    reset = 1'b0; d_req = 1'b1;
    n = 0;
    while (mem_ready == 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      chk("hold_busy", busy, 0);
      chk("hold_cs", mem_cs, 0);
      chk("hold_ack", d_ack, 0);
    end
    chk("hold_cycles", n, 4);
    wait_ack(40, cyc, csn, ia, da);
    chk("post_which", {ia, da}, 2'b01);
    chk("post_data", d_rdata, PAT_DB);
    d_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
